// File: rtl/arm_imm_pkg.sv
// Shared definitions for the ARM data-processing immediate encoder.
// The rotate helper is written so the decode side (Val2) can reuse it.
package arm_imm_pkg;

  localparam int SHIFTER_W = 12;
  localparam int IMM8_W    = 8;
  localparam int ROT_W     = 4;
  localparam int ROT_MAX   = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // True 32-bit rotate right; an amount of 0 returns the value unchanged.
  function automatic logic [31:0] rotr32(input logic [31:0] value, input logic [4:0] amt);
    logic [63:0] doubled;
    doubled = {value, value} >> amt;
    return doubled[31:0];
  endfunction

endpackage

// File: rtl/arm_imm_encoder_if.sv
// Request/response bundle for the immediate encoder.
// master = requester side, slave = encoder side.
interface arm_imm_encoder_if;
  import arm_imm_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_value;
  logic                 out_valid;
  logic                 out_ready;
  logic [SHIFTER_W-1:0] out_shifter;
  logic                 out_found;
  logic                 out_inverted;

  modport master (
    output in_valid, in_value, out_ready,
    input  in_ready, out_valid, out_shifter, out_found, out_inverted
  );

  modport slave (
    input  in_valid, in_value, out_ready,
    output in_ready, out_valid, out_shifter, out_found, out_inverted
  );

endinterface

// File: rtl/arm_imm_rot_check.sv
// Combinational test of one rotation: does (value ROL 2*rot) fit in 8 bits?
// If it does, imm8 rotated right by 2*rot reproduces value.
module arm_imm_rot_check
  import arm_imm_pkg::*;
(
  input  logic [31:0]       value,
  input  logic [ROT_W-1:0]  rot,
  output logic              fit,
  output logic [IMM8_W-1:0] imm8
);

  logic [4:0]  ror_amt;
  logic [31:0] cand;

  // ROL by 2r is ROR by (32 - 2r) mod 32; the 5-bit wrap handles r=0.
  always_comb begin
    ror_amt = 5'd0 - {rot, 1'b0};
    cand    = rotr32(value, ror_amt);
    fit     = (cand[31:IMM8_W] == '0);
    imm8    = cand[IMM8_W-1:0];
  end

endmodule

// File: rtl/arm_imm_encoder.sv
// Iterative ARM immediate encoder: tests one rotation per cycle, plain
// form first, then the inverted (MVN) form, lowest rotation wins.
module arm_imm_encoder
  import arm_imm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  arm_imm_encoder_if.slave  bus
);

  state_t               state_reg, state_next;
  logic [31:0]          val_q, val_next;
  logic [ROT_W-1:0]     rot_q, rot_next;
  logic [SHIFTER_W-1:0] shifter_reg, shifter_next;
  logic                 found_reg, found_next;
  logic                 inv_reg, inv_next;

  logic                 fit_p, fit_n;
  logic [IMM8_W-1:0]    imm_p, imm_n;

  arm_imm_rot_check u_check_p (
    .value (val_q),
    .rot   (rot_q),
    .fit   (fit_p),
    .imm8  (imm_p)
  );

  arm_imm_rot_check u_check_n (
    .value (~val_q),
    .rot   (rot_q),
    .fit   (fit_n),
    .imm8  (imm_n)
  );

  // State, operand and result registers; reset discards any request in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      val_q       <= '0;
      rot_q       <= '0;
      shifter_reg <= '0;
      found_reg   <= 1'b0;
      inv_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      val_q       <= val_next;
      rot_q       <= rot_next;
      shifter_reg <= shifter_next;
      found_reg   <= found_next;
      inv_reg     <= inv_next;
    end
  end

  // Next-state and result selection; results only change when leaving SEARCH.
  always_comb begin
    state_next   = state_reg;
    val_next     = val_q;
    rot_next     = rot_q;
    shifter_next = shifter_reg;
    found_next   = found_reg;
    inv_next     = inv_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          val_next   = bus.in_value;
          rot_next   = '0;
          state_next = SEARCH;
        end
      end
      SEARCH: begin
        if (fit_p) begin
          shifter_next = {rot_q, imm_p};
          found_next   = 1'b1;
          inv_next     = 1'b0;
          state_next   = DONE;
        end else if (fit_n) begin
          shifter_next = {rot_q, imm_n};
          found_next   = 1'b1;
          inv_next     = 1'b1;
          state_next   = DONE;
        end else if (rot_q == ROT_W'(ROT_MAX)) begin
          shifter_next = '0;
          found_next   = 1'b0;
          inv_next     = 1'b0;
          state_next   = DONE;
        end else begin
          rot_next = rot_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags decode straight from the registered state.
  always_comb begin
    bus.in_ready     = (state_reg == IDLE);
    bus.out_valid    = (state_reg == DONE);
    bus.out_shifter  = shifter_reg;
    bus.out_found    = found_reg;
    bus.out_inverted = inv_reg;
  end

endmodule

// File: doc/arm_imm_encoder.md
# arm_imm_encoder

Iterative encoder for the ARM data-processing immediate form: takes a 32-bit constant and searches for a 12-bit shifter operand {rotate_imm[3:0], imm8[7:0]} such that the constant equals imm8 rotated right by 2·rotate_imm. It is the inverse of the EXE-stage Val2 immediate decode. It feeds the instruction-stream generator and test infrastructure, which use it to build MOV/MVN immediates. One rotation is tested per cycle, and valid/ready handshakes are used on both sides.

## Interface
- No parameters; widths are fixed by the ISA (32-bit value, 12-bit shifter field).
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept; high only in IDLE
- in_value  in  32  constant to encode
- out_valid  out  1  result valid; high only in DONE
- out_ready  in  1  consumer accepts result
- out_shifter  out  12  {rotate_imm, imm8}; 12'h000 when not found
- out_found  out  1  an encoding exists
- out_inverted  out  1  encoding is for ~in_value (use MVN)

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE: in_ready=1. When in_valid is high, the encoder latches in_value into val_q, sets rot_q=0, and moves to SEARCH.
- SEARCH, per cycle, with r=rot_q:
  - cand_p = val_q ROL 2r; cand_n = (~val_q) ROL 2r.
  - fit_p = (cand_p[31:8]==0); fit_n = (cand_n[31:8]==0).
- Priority within a cycle: fit_p beats fit_n. Across cycles, the lowest r wins, so the first hit ends the search.
- On a hit: the encoder registers out_shifter={r[3:0], cand[7:0]}, out_found=1, and out_inverted=!fit_p, then moves to DONE.
- On no hit with r==15: the encoder registers out_shifter=0, out_found=0, and out_inverted=0, then moves to DONE.
- Otherwise rot_q increments; the 4-bit counter never wraps in SEARCH.
- DONE: out_valid=1. Outputs hold stable until out_ready=1, then the FSM returns to IDLE.
- in_value changes outside the acceptance cycle are ignored.
- Rotation is a true 32-bit rotate. ROL by 0 is the identity. The 2r shift amount is 5 bits, 0..30.

## Timing
- Acceptance is at cycle 0, when in_valid and in_ready are both high. Rotation r is tested in cycle r+1.
- A hit at rotation k gives out_valid high in cycle k+2. Minimum latency is 2 cycles; maximum is 17, including the not-found case.
- The throughput bound is one request per (latency + 1) cycles. Back-to-back acceptance is impossible: in_ready is low in SEARCH and DONE.
- A DONE→IDLE transition on out_ready allows a new acceptance in the next cycle. There is no same-cycle bypass.
- Reset values, when rst_n=0 on an edge: state=IDLE, in_ready=1, out_valid=0, out_shifter=0, out_found=0, out_inverted=0, rot_q=0, val_q=0.
- Reset mid-SEARCH or in DONE discards the request, and no result is produced.
- Reset dominates in_valid and out_ready in the same cycle.

## Structure
- Shared package arm_imm_pkg:
  - state enum {IDLE, SEARCH, DONE}.
  - Constants: SHIFTER_W=12, IMM8_W=8, ROT_W=4, ROT_MAX=15.
  - A rotate-right function that the decode side can also reuse.
- One combinational sub-module, arm_imm_rot_check:
  - Inputs: value[31:0], rot[3:0].
  - Outputs: fit, imm8[7:0].
  - Instantiate it twice, once for val_q and once for ~val_q.
- The top level holds the FSM, val_q, rot_q, and the output registers.

## Test plan
- 0x000000FF → shifter 0x0FF, found=1, inv=0, out_valid at cycle 2.
- 0xFF000000 → shifter 0x4FF, found=1, inv=0, out_valid at cycle 6.
- 0x000003FC → shifter 0xFFF (r=15), out_valid at cycle 17.
- 0xFFFFFF00 → shifter 0x0FF, found=1, inv=1, cycle 2.
- Not found and priority:
  - 0x00000101 → found=0, shifter 0x000, cycle 17.
  - 0x00000000 → shifter 0x000, found=1, inv=0; the plain form wins over the inverted form.
- Handshake and reset:
  - 0xF000000F → 0x2FF with out_ready held low 5 cycles: outputs stay stable and in_ready stays 0.
  - rst_n low at cycle 4 of a search → all outputs at reset values next cycle, and a new request is accepted afterward.
